// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-result queue: instruction width,
// branch-type encodings, the predictor/fetch packet layouts and a clog2 helper.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int BT_W   = 4;

  typedef enum logic [BT_W-1:0] {
    BT_NONE   = 4'd0,
    BT_BRANCH = 4'd1,
    BT_JAL    = 4'd2,
    BT_JALR   = 4'd3,
    BT_CALL   = 4'd4,
    BT_RET    = 4'd5
  } branch_type_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int DEF_FETCH_WIDTH = 4;
  localparam int DEF_ADDR_W      = 64;
  localparam int DEF_SEL_W       = clog2(DEF_FETCH_WIDTH);

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] target;
    logic [BT_W-1:0]       branch_type;
    logic [DEF_SEL_W-1:0]  select;
    logic                  taken;
  } branch_predict_pack_t;

  typedef struct packed {
    logic [DEF_FETCH_WIDTH-1:0]        valids;
    logic [DEF_ADDR_W-1:0]             pc;
    logic [INST_W*DEF_FETCH_WIDTH-1:0] insts;
    branch_predict_pack_t              bpp;
  } fetch_pack_t;

endpackage

// File: rtl/fetch_slot_mask.sv
// Per-slot valid mask of a fetch block: slots before the PC offset are dropped,
// and slots after a taken predicted or presolved branch are cut off.
module fetch_slot_mask
  import fetch_pkg::*;
#(
  parameter  int FETCH_WIDTH = 4,
  localparam int SEL_W       = clog2(FETCH_WIDTH)
) (
  input  logic [SEL_W-1:0]       offset,
  input  logic                   predict_valid,
  input  logic                   predict_taken,
  input  logic [SEL_W-1:0]       predict_select,
  input  logic                   presolve_valid,
  input  logic                   presolve_taken,
  input  logic [SEL_W-1:0]       presolve_select,
  output logic [FETCH_WIDTH-1:0] valids
);

  logic predict_cut;
  logic presolve_cut;

  assign predict_cut  = predict_valid & predict_taken;
  assign presolve_cut = presolve_valid & presolve_taken;

  // Each slot must lie inside [offset, first taken branch].
  always_comb begin
    valids = {FETCH_WIDTH{1'b0}};
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      valids[i] = (SEL_W'(i) >= offset)
                & (~predict_cut  | (SEL_W'(i) <= predict_select))
                & (~presolve_cut | (SEL_W'(i) <= presolve_select));
    end
  end

endmodule

// File: rtl/fetch_res_queue.sv
// Fetch-result stage: masks the incoming fetch block and buffers the resulting
// packets in a DEPTH-entry FIFO that decode drains with ready/valid.
module fetch_res_queue
  import fetch_pkg::*;
#(
  parameter  int FETCH_WIDTH = 4,
  parameter  int DEPTH       = 4,
  parameter  int ADDR_W      = 64,
  localparam int SEL_W       = clog2(FETCH_WIDTH),
  localparam int CNT_W       = clog2(DEPTH + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_i_flush,
  input  logic                          io_i_stall,
  input  logic                          io_i_fetch_valid,
  output logic                          io_o_fetch_ready,
  input  logic [ADDR_W-1:0]             io_i_pc,
  input  logic [INST_W*FETCH_WIDTH-1:0] io_i_fetch_res,
  input  logic                          io_i_branch_predict_pack_valid,
  input  logic [ADDR_W-1:0]             io_i_branch_predict_pack_target,
  input  logic [BT_W-1:0]               io_i_branch_predict_pack_branch_type,
  input  logic [SEL_W-1:0]              io_i_branch_predict_pack_select,
  input  logic                          io_i_branch_predict_pack_taken,
  input  logic                          io_i_branch_presolve_pack_valid,
  input  logic                          io_i_branch_presolve_pack_taken,
  input  logic [SEL_W-1:0]              io_i_branch_presolve_pack_select,
  output logic                          io_o_fetch_pack_valid,
  input  logic                          io_i_fetch_pack_ready,
  output logic [FETCH_WIDTH-1:0]        io_o_fetch_pack_bits_valids,
  output logic [ADDR_W-1:0]             io_o_fetch_pack_bits_pc,
  output logic [INST_W*FETCH_WIDTH-1:0] io_o_fetch_pack_bits_insts,
  output logic                          io_o_fetch_pack_bits_branch_predict_pack_valid,
  output logic [ADDR_W-1:0]             io_o_fetch_pack_bits_branch_predict_pack_target,
  output logic [BT_W-1:0]               io_o_fetch_pack_bits_branch_predict_pack_branch_type,
  output logic [SEL_W-1:0]              io_o_fetch_pack_bits_branch_predict_pack_select,
  output logic                          io_o_fetch_pack_bits_branch_predict_pack_taken,
  output logic [CNT_W-1:0]              io_o_count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int LOW_W = SEL_W + 2;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0]        valids;
    logic [ADDR_W-1:0]             pc;
    logic [INST_W*FETCH_WIDTH-1:0] insts;
    logic                          bpp_valid;
    logic [ADDR_W-1:0]             bpp_target;
    logic [BT_W-1:0]               bpp_branch_type;
    logic [SEL_W-1:0]              bpp_select;
    logic                          bpp_taken;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [CNT_W-1:0]       count;
  logic [FETCH_WIDTH-1:0] slot_valids;
  logic [ADDR_W-1:0]      aligned_pc;
  entry_t                 in_entry;
  entry_t                 head_entry;
  logic                   enq;
  logic                   deq;

  fetch_slot_mask #(
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_slot_mask (
    .offset          (io_i_pc[SEL_W+1:2]),
    .predict_valid   (io_i_branch_predict_pack_valid),
    .predict_taken   (io_i_branch_predict_pack_taken),
    .predict_select  (io_i_branch_predict_pack_select),
    .presolve_valid  (io_i_branch_presolve_pack_valid),
    .presolve_taken  (io_i_branch_presolve_pack_taken),
    .presolve_select (io_i_branch_presolve_pack_select),
    .valids          (slot_valids)
  );

  assign aligned_pc = io_i_pc & ~{{(ADDR_W-LOW_W){1'b0}}, {LOW_W{1'b1}}};

  assign in_entry.valids          = slot_valids;
  assign in_entry.pc              = aligned_pc;
  assign in_entry.insts           = io_i_fetch_res;
  assign in_entry.bpp_valid       = io_i_branch_predict_pack_valid;
  assign in_entry.bpp_target      = io_i_branch_predict_pack_target;
  assign in_entry.bpp_branch_type = io_i_branch_predict_pack_branch_type;
  assign in_entry.bpp_select      = io_i_branch_predict_pack_select;
  assign in_entry.bpp_taken       = io_i_branch_predict_pack_taken;

  // Ready ignores a same-cycle dequeue, so a full queue stalls fetch for a cycle.
  assign io_o_fetch_ready      = (count != CNT_W'(DEPTH));
  assign io_o_fetch_pack_valid = (count != {CNT_W{1'b0}}) & ~io_i_flush;
  assign io_o_count            = count;

  assign enq = io_i_fetch_valid & ~io_i_stall & ~io_i_flush & io_o_fetch_ready
             & (|slot_valids);
  assign deq = io_o_fetch_pack_valid & io_i_fetch_pack_ready;

  // Packet storage, written on enqueue only and deliberately left unreset.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem[tail] <= in_entry;
    end
  end

  // Head/tail pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= {PTR_W{1'b0}};
      tail  <= {PTR_W{1'b0}};
      count <= {CNT_W{1'b0}};
    end else if (io_i_flush) begin
      head  <= {PTR_W{1'b0}};
      tail  <= {PTR_W{1'b0}};
      count <= {CNT_W{1'b0}};
    end else begin
      if (enq) begin
        tail <= tail + PTR_W'(1);
      end
      if (deq) begin
        head <= head + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_entry = mem[head];

  assign io_o_fetch_pack_bits_valids                          = head_entry.valids;
  assign io_o_fetch_pack_bits_pc                              = head_entry.pc;
  assign io_o_fetch_pack_bits_insts                           = head_entry.insts;
  assign io_o_fetch_pack_bits_branch_predict_pack_valid       = head_entry.bpp_valid;
  assign io_o_fetch_pack_bits_branch_predict_pack_target      = head_entry.bpp_target;
  assign io_o_fetch_pack_bits_branch_predict_pack_branch_type = head_entry.bpp_branch_type;
  assign io_o_fetch_pack_bits_branch_predict_pack_select      = head_entry.bpp_select;
  assign io_o_fetch_pack_bits_branch_predict_pack_taken       = head_entry.bpp_taken;

endmodule

// File: tb/tb_fetch_res_queue.sv
// Randomized bench for fetch_res_queue against a queue-based packet model.
module tb_fetch_res_queue;

  localparam int FW    = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 64;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           flush, stall, fv, ready_out, pr;
  logic [AW-1:0]  pc;
  logic [127:0]   insts;
  logic           bpv, btk, psv, pst;
  logic [AW-1:0]  btgt;
  logic [3:0]     btype;
  logic [1:0]     bsel, pss;
  logic           o_valid;
  logic [3:0]     o_valids;
  logic [AW-1:0]  o_pc;
  logic [127:0]   o_insts;
  logic           o_bv, o_btk;
  logic [AW-1:0]  o_btgt;
  logic [3:0]     o_btype;
  logic [1:0]     o_bsel;
  logic [2:0]     o_count;

  typedef struct {
    logic [3:0]    v;
    logic [AW-1:0] pc;
    logic [127:0]  insts;
    logic          bv;
    logic [AW-1:0] btgt;
    logic [3:0]    btype;
    logic [1:0]    bsel;
    logic          btk;
  } pkt_t;

  pkt_t mq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  fetch_res_queue dut (
    .clock                                                (clock),
    .reset                                                (reset),
    .io_i_flush                                           (flush),
    .io_i_stall                                           (stall),
    .io_i_fetch_valid                                     (fv),
    .io_o_fetch_ready                                     (ready_out),
    .io_i_pc                                              (pc),
    .io_i_fetch_res                                       (insts),
    .io_i_branch_predict_pack_valid                       (bpv),
    .io_i_branch_predict_pack_target                      (btgt),
    .io_i_branch_predict_pack_branch_type                 (btype),
    .io_i_branch_predict_pack_select                      (bsel),
    .io_i_branch_predict_pack_taken                       (btk),
    .io_i_branch_presolve_pack_valid                      (psv),
    .io_i_branch_presolve_pack_taken                      (pst),
    .io_i_branch_presolve_pack_select                     (pss),
    .io_o_fetch_pack_valid                                (o_valid),
    .io_i_fetch_pack_ready                                (pr),
    .io_o_fetch_pack_bits_valids                          (o_valids),
    .io_o_fetch_pack_bits_pc                              (o_pc),
    .io_o_fetch_pack_bits_insts                           (o_insts),
    .io_o_fetch_pack_bits_branch_predict_pack_valid       (o_bv),
    .io_o_fetch_pack_bits_branch_predict_pack_target      (o_btgt),
    .io_o_fetch_pack_bits_branch_predict_pack_branch_type (o_btype),
    .io_o_fetch_pack_bits_branch_predict_pack_select      (o_bsel),
    .io_o_fetch_pack_bits_branch_predict_pack_taken       (o_btk),
    .io_o_count                                           (o_count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Valid slots form the range [pc offset, earliest taken branch slot].
  function automatic logic [3:0] model_valids();
    int lo, hi;
    logic [3:0] m;
    lo = int'(pc[3:2]);
    hi = FW - 1;
    if (bpv && btk && int'(bsel) < hi) hi = int'(bsel);
    if (psv && pst && int'(pss) < hi) hi = int'(pss);
    m = 4'b0000;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic clear_inputs();
    flush = 1'b0; stall = 1'b0; fv = 1'b0; pr = 1'b0;
    pc = 64'd0; insts = 128'd0;
    bpv = 1'b0; btk = 1'b0; btgt = 64'd0; btype = 4'd0; bsel = 2'd0;
    psv = 1'b0; pst = 1'b0; pss = 2'd0;
  endtask

  task automatic new_block(input logic [AW-1:0] p);
    fv = 1'b1;
    pc = p;
    insts = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic randomize_inputs();
    fv    = ($urandom_range(0, 9) < 8);
    stall = ($urandom_range(0, 9) == 0);
    flush = ($urandom_range(0, 19) == 0);
    pr    = ($urandom_range(0, 9) < 6);
    pc    = {$urandom, $urandom};
    insts = {$urandom, $urandom, $urandom, $urandom};
    bpv   = 1'($urandom); btk = 1'($urandom); bsel = 2'($urandom);
    btgt  = {$urandom, $urandom}; btype = 4'($urandom);
    psv   = 1'($urandom); pst = 1'($urandom); pss = 2'($urandom);
  endtask

  // Check outputs at the falling edge, then advance the model over the rising edge.
  task automatic cycle();
    pkt_t h, n;
    logic exp_valid, exp_ready, do_enq, do_deq;
    @(negedge clock);
    exp_valid = (mq.size() != 0) && !flush;
    exp_ready = (mq.size() != DEPTH);
    check("out_valid", o_valid, exp_valid);
    check("fetch_ready", ready_out, exp_ready);
    check("count", o_count, mq.size());
    if (exp_valid) begin
      h = mq[0];
      check("valids", o_valids, h.v);
      check("pc", o_pc, h.pc);
      check("insts", o_insts, h.insts);
      check("bpp_valid", o_bv, h.bv);
      check("bpp_target", o_btgt, h.btgt);
      check("bpp_type", o_btype, h.btype);
      check("bpp_select", o_bsel, h.bsel);
      check("bpp_taken", o_btk, h.btk);
    end
    n.v = model_valids();
    n.pc = {pc[AW-1:4], 4'b0000};
    n.insts = insts; n.bv = bpv; n.btgt = btgt; n.btype = btype; n.bsel = bsel; n.btk = btk;
    do_enq = fv && !stall && !flush && exp_ready && (n.v != 4'b0000);
    do_deq = exp_valid && pr;
    @(posedge clock);
    if (flush) mq.delete();
    else begin
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back(n);
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_ready", ready_out, 1'b1);
    check("rst_count", o_count, 3'd0);
    reset = 1'b0;

    // Offset 2 block, no branches.
    pr = 1'b1;
    new_block(64'h8000_0008);
    cycle();
    fv = 1'b0;
    check("t1_valid", o_valid, 1'b1);
    check("t1_valids", o_valids, 4'b1100);
    check("t1_pc", o_pc, 64'h8000_0000);
    cycle();

    // Predicted taken branch in slot 2.
    new_block(64'h8000_0000);
    bpv = 1'b1; btk = 1'b1; bsel = 2'd2; btgt = 64'h0000_0000_8000_1234; btype = 4'd2;
    cycle();
    clear_inputs();
    pr = 1'b1;
    check("t2_valids", o_valids, 4'b0111);
    check("t2_select", o_bsel, 2'd2);
    check("t2_target", o_btgt, 64'h0000_0000_8000_1234);
    cycle();

    // Predict and presolve both taken; then an all-zero block that must be dropped.
    pr = 1'b0;
    new_block(64'h8000_0004);
    bpv = 1'b1; btk = 1'b1; bsel = 2'd3; psv = 1'b1; pst = 1'b1; pss = 2'd1;
    cycle();
    check("t3_valids", o_valids, 4'b0010);
    new_block(64'h8000_000C);
    bpv = 1'b0; btk = 1'b0;
    cycle();
    check("t3_drop_count", o_count, 3'd1);
    clear_inputs();
    pr = 1'b1;
    repeat (2) cycle();

    // Fill to full, offer a fifth, then drain while fetch keeps streaming.
    pr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      new_block({32'h8000_0000, 28'd0, 4'(k * 4)} & 64'hFFFF_FFFF_FFFF_FFF0);
      cycle();
    end
    check("full_count", o_count, 3'd4);
    check("full_ready", ready_out, 1'b0);
    new_block(64'h9000_0000);
    cycle();
    check("full_fifth", o_count, 3'd4);
    pr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      new_block({$urandom, $urandom});
      cycle();
    end
    fv = 1'b0;
    repeat (5) cycle();

    // Flush with three entries held and a valid input offered.
    pr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      new_block(64'hA000_0000);
      cycle();
    end
    check("fl_count3", o_count, 3'd3);
    flush = 1'b1;
    new_block(64'hB000_0000);
    cycle();
    flush = 1'b0;
    fv = 1'b0;
    check("fl_count0", o_count, 3'd0);
    check("fl_ready", ready_out, 1'b1);
    cycle();

    // Asynchronous reset in the middle of a burst.
    for (int k = 0; k < 2; k++) begin
      new_block(64'hC000_0000);
      cycle();
    end
    check("ar_count2", o_count, 3'd2);
    new_block(64'hC000_0010);
    #1 reset = 1'b1;
    #1;
    check("ar_valid", o_valid, 1'b0);
    check("ar_count", o_count, 3'd0);
    mq.delete();
    #1 reset = 1'b0;
    cycle();
    fv = 1'b0;
    check("ar_first", o_valid, 1'b1);
    cycle();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      randomize_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_res_queue.md
Name: fetch_res_queue

Overview:
Parametrised successor of the fetch-result stage. Takes one aligned fetch block of FETCH_WIDTH instructions per cycle from the I-side. Computes per-slot valids from the PC offset, the branch-predictor pack and the pre-decode (presolve) redirect, then buffers the resulting fetch packets in a DEPTH-entry FIFO. Decode drains the FIFO through a ready/valid handshake. Sits between the fetch response path and decode; decouples fetch from decode stalls.

Parameters:
FETCH_WIDTH, 4, instructions per fetch block; power of 2, >=2
DEPTH, 4, fetch-packet entries in the FIFO; power of 2, >=2
ADDR_W, 64, PC / target width
SEL_W, log2(FETCH_WIDTH), slot-index width (derived, not overridable)

Ports:
clock  in  1  clock
reset  in  1  asynchronous reset, active-high
io_i_flush  in  1  pipeline flush/redirect
io_i_stall  in  1  fetch stall; suppresses enqueue
io_i_fetch_valid  in  1  fetch response valid
io_o_fetch_ready  out  1  FIFO can accept (= not full)
io_i_pc  in  ADDR_W  PC of the first requested instruction
io_i_fetch_res  in  32*FETCH_WIDTH  fetch block; slot i = bits [32i+31:32i]
io_i_branch_predict_pack_valid  in  1  predictor pack valid
io_i_branch_predict_pack_target  in  ADDR_W  predicted target
io_i_branch_predict_pack_branch_type  in  4  branch type code
io_i_branch_predict_pack_select  in  SEL_W  slot holding the predicted branch
io_i_branch_predict_pack_taken  in  1  predicted taken
io_i_branch_presolve_pack_valid  in  1  presolve result valid
io_i_branch_presolve_pack_taken  in  1  presolve redirect taken
io_i_branch_presolve_pack_select  in  SEL_W  slot of the presolved branch
io_o_fetch_pack_valid  out  1  head entry valid
io_i_fetch_pack_ready  in  1  decode accepts head
io_o_fetch_pack_bits_valids  out  FETCH_WIDTH  per-slot valids of head
io_o_fetch_pack_bits_pc  out  ADDR_W  block-aligned PC of head
io_o_fetch_pack_bits_insts  out  32*FETCH_WIDTH  instructions of head
io_o_fetch_pack_bits_branch_predict_pack_{valid,target,branch_type,select,taken}  out  1/ADDR_W/4/SEL_W/1  stored predictor pack
io_o_count  out  clog2(DEPTH+1)  occupied entries

Behaviour:
- Alignment: OFF = io_i_pc[SEL_W+1:2]. Stored pc = io_i_pc with bits [SEL_W+1:0] zeroed.
- Slot i is valid iff all of the following hold:
  - i >= OFF;
  - NOT (predict valid & taken) OR i <= predict select;
  - NOT (presolve valid & taken) OR i <= presolve select.
- enq = io_i_fetch_valid & ~io_i_stall & ~io_i_flush & io_o_fetch_ready & (|valids).
- A packet whose valids are all zero is dropped; it is not enqueued.
- deq = io_o_fetch_pack_valid & io_i_fetch_pack_ready.
- io_o_fetch_ready = (count != DEPTH). There is no full-bypass: at full, a same-cycle deq does not make ready high.
- No empty-bypass. Latency from enq to io_o_fetch_pack_valid is 1 cycle. Outputs are driven from the head entry.
- io_o_fetch_pack_valid = (count != 0) & ~io_i_flush.
- Simultaneous enq and deq: count is unchanged, and both pointers advance.
- Pointers are SEL-free, log2(DEPTH) bits wide, and wrap modulo DEPTH. count tracks 0..DEPTH.
- Flush: the input in the flush cycle is discarded and deq is blocked. The next cycle has head=tail=0 and count=0. Flush overrides enq and deq.
- Reset (any time, including mid-burst): head=0, tail=0, count=0. io_o_fetch_pack_valid=0, io_o_fetch_ready=1.
- Storage contents are not reset. Output bits are don't-care while valid=0.
- The stored predictor pack is copied unmodified. The presolve pack is not stored; it only masks valids.

Decomposition:
- Package fetch_pkg holds: INST_W=32; the branch_type width and encodings; the branch_predict_pack struct (valid, target, branch_type, select, taken); the fetch_pack struct (valids, pc, insts, bpp); helper clog2.
- Sub-module fetch_slot_mask (combinational): pc offset + predict/presolve packs -> FETCH_WIDTH valids.
- The FIFO is kept inline.

Test Plan:
- FW=4, pc=0x8000_0008, no predict/presolve, fetch_valid=1, ready=1 -> next cycle: out valid=1, valids=4'b1100, pc=0x8000_0000.
- pc=0x8000_0000, predict valid=1, taken=1, select=2 -> valids=4'b0111; stored pack select=2, target preserved.
- pc=0x8000_0004, predict taken select=3, presolve taken select=1 -> valids=4'b0010. Then pc=0x8000_000C with presolve taken select=1 -> all-zero, not enqueued, count unchanged.
- fetch_pack_ready=0, 4 back-to-back enqueues -> count=4, fetch_ready=0. 5th input not taken. Raise ready with valid input asserted -> one deq per cycle, enq resumes the cycle after count<4, FIFO order preserved across pointer wrap.
- count=3, flush with fetch_valid=1 -> out valid=0 that cycle, next cycle count=0 and fetch_ready=1, flushed input absent.
- Assert reset asynchronously mid-burst with count=2 -> out valid=0, count=0 immediately. After release, the first enqueue appears 1 cycle later.
